hilo_mdu_ctrl: RTL and testbench

//  Sequences the multi-cycle multiply/divide unit and owns the HI/LO register pair in the EX stage.

---
 rtl/hilo_mdu_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_hilo_mdu_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu_ctrl.sv
// EX-stage multiply/divide sequencer and HI/LO register owner.
// Runs the MUL_STAGES multiply wait or the 32-step restoring divide, then commits once.
module hilo_mdu_ctrl #(
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  input  logic        stall_ext_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        hilo_we_o
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL     = 3'd1,
    DIV     = 3'd2,
    DIV_FIX = 3'd3,
    COMMIT  = 3'd4
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           mul_signed;
  logic [W-1:0]   q_r;
  logic [W-1:0]   r_r;
  logic [W-1:0]   d_r;
  logic           neg_q;
  logic           neg_r;
  logic [W-1:0]   staged_hi;
  logic [W-1:0]   staged_lo;

  logic           is_mul_c;
  logic           is_div_c;
  logic           div_signed_c;
  logic           a_neg_c;
  logic           b_neg_c;
  logic [W-1:0]   a_abs_c;
  logic [W-1:0]   b_abs_c;
  logic [2*W-1:0] mul_a_ext;
  logic [2*W-1:0] mul_b_ext;
  logic [2*W-1:0] product;
  logic [W:0]     trial;
  logic [W:0]     diff;
  logic           ge;
  logic [W-1:0]   r_next;
  logic [W-1:0]   q_next;

  // Decode of the incoming HILO-writing instruction
  assign is_mul_c     = (op_i == EXE_MULT_OP) | (op_i == EXE_MULTU_OP);
  assign is_div_c     = (op_i == EXE_DIV_OP)  | (op_i == EXE_DIVU_OP);
  assign div_signed_c = (op_i == EXE_DIV_OP);
  assign a_neg_c      = div_signed_c & a_i[W-1];
  assign b_neg_c      = div_signed_c & b_i[W-1];
  assign a_abs_c      = a_neg_c ? W'(-a_i) : a_i;
  assign b_abs_c      = b_neg_c ? W'(-b_i) : b_i;

  assign stall_o = ~flush_i &
                   (((state == IDLE) & start_i & (is_mul_c | is_div_c)) |
                    (state == MUL) | (state == DIV) | (state == DIV_FIX));

  // Sign/zero extension lets one 64-bit multiplier serve MULT and MULTU
  assign mul_a_ext = {{W{mul_signed & op_a[W-1]}}, op_a};
  assign mul_b_ext = {{W{mul_signed & op_b[W-1]}}, op_b};
  assign product   = mul_a_ext * mul_b_ext;

  // Restoring step; the 33-bit trial keeps the bit shifted out of the remainder
  assign trial  = {r_r, q_r[W-1]};
  assign diff   = trial - {1'b0, d_r};
  assign ge     = ~diff[W];
  assign r_next = ge ? diff[W-1:0] : trial[W-1:0];
  assign q_next = {q_r[W-2:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      mul_signed <= 1'b0;
      q_r        <= '0;
      r_r        <= '0;
      d_r        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      staged_hi  <= '0;
      staged_lo  <= '0;
      hi_o       <= '0;
      lo_o       <= '0;
      hilo_we_o  <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      hilo_we_o <= 1'b0;
      if (flush_i) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i & ~stall_ext_i) begin
              if (is_mul_c) begin
                op_a       <= a_i;
                op_b       <= b_i;
                mul_signed <= (op_i == EXE_MULT_OP);
                cnt        <= CW'(MUL_STAGES - 1);
                state      <= MUL;
                busy_o     <= 1'b1;
              end else if (is_div_c) begin
                op_a   <= a_i;
                op_b   <= b_i;
                q_r    <= a_abs_c;
                r_r    <= '0;
                d_r    <= b_abs_c;
                neg_q  <= a_neg_c ^ b_neg_c;
                neg_r  <= a_neg_c;
                cnt    <= CW'(31);
                state  <= DIV;
                busy_o <= 1'b1;
              end else if (op_i == EXE_MTHI_OP) begin
                hi_o      <= a_i;
                hilo_we_o <= 1'b1;
              end else if (op_i == EXE_MTLO_OP) begin
                lo_o      <= a_i;
                hilo_we_o <= 1'b1;
              end
            end
          end
          MUL: begin
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
              staged_hi <= product[2*W-1:W];
              staged_lo <= product[W-1:0];
              state     <= COMMIT;
            end
          end
          DIV: begin
            r_r <= r_next;
            q_r <= q_next;
            cnt <= cnt - CW'(1);
            if (cnt == '0) state <= DIV_FIX;
          end
          DIV_FIX: begin
            // Divide by zero reports all-ones quotient and the raw dividend
            if (d_r == '0) begin
              staged_lo <= '1;
              staged_hi <= op_a;
            end else begin
              staged_lo <= neg_q ? W'(-q_r) : q_r;
              staged_hi <= neg_r ? W'(-r_r) : r_r;
            end
            state <= COMMIT;
          end
          COMMIT: begin
            if (~stall_ext_i) begin
              hi_o      <= staged_hi;
              lo_o      <= staged_lo;
              hilo_we_o <= 1'b1;
              state     <= IDLE;
              busy_o    <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Scoreboard bench for hilo_mdu_ctrl: directed ops push expected HI/LO, a monitor
// pops and compares on every hilo_we_o pulse.
module tb_hilo_mdu_ctrl;

  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [7:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        stall_ext_i;
  logic        stall_o;
  logic        busy_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        hilo_we_o;

  int compared   = 0;
  int mismatched = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  hilo_mdu_ctrl #(.MUL_STAGES(2)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .stall_ext_i(stall_ext_i), .stall_o(stall_o), .busy_o(busy_o),
    .hi_o(hi_o), .lo_o(lo_o), .hilo_we_o(hilo_we_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && hilo_we_o) begin
      if (exp_q.size() == 0) begin
        chk("spurious_hilo_we", {63'b0, hilo_we_o}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("hi_o", {32'b0, hi_o}, {32'b0, e[63:32]});
        chk("lo_o", {32'b0, lo_o}, {32'b0, e[31:0]});
      end
    end
  end

  // Pipeline-style issue: instruction stays in EX until stall_o and stall_ext_i are both low
  task automatic issue(input string name, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_stall,
                       input logic [31:0] ehi, input logic [31:0] elo);
    int   stalls;
    int   guard;
    logic adv;
    stalls = 0;
    guard  = 0;
    adv    = 1'b0;
    exp_q.push_back({ehi, elo});
    m_hi = ehi;
    m_lo = elo;
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    while (!adv && guard < 200) begin
      @(negedge clk);
      adv = ~stall_o & ~stall_ext_i;
      if (stall_o) stalls++;
      @(posedge clk); #1;
      guard++;
    end
    start_i = 1'b0;
    chk({name, "_advanced"}, {63'b0, adv}, 64'd1);
    chk({name, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    flush_i = 1'b0; stall_ext_i = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_hi", {32'b0, hi_o}, 64'd0);
    chk("reset_lo", {32'b0, lo_o}, 64'd0);
    chk("reset_busy", {63'b0, busy_o}, 64'd0);
    chk("reset_we", {63'b0, hilo_we_o}, 64'd0);
    chk("reset_stall", {63'b0, stall_o}, 64'd0);
    @(posedge clk); #1;

    issue("mtlo",   OP_MTLO,  32'h0000_0055, 32'h0, 0, 32'h0000_0000, 32'h0000_0055);
    issue("mthi",   OP_MTHI,  32'h1234_5678, 32'h0, 0, 32'h1234_5678, 32'h0000_0055);
    issue("mult",   OP_MULT,  32'hFFFF_FFFD, 32'h5, 3, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    issue("multu",  OP_MULTU, 32'hFFFF_FFFF, 32'h2, 3, 32'h0000_0001, 32'hFFFF_FFFE);
    issue("divu",   OP_DIVU,  32'd100, 32'd7, 34, 32'h0000_0002, 32'h0000_000E);
    issue("div_neg", OP_DIV,  32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue("div_zero", OP_DIV, 32'd1234, 32'd0, 34, 32'h0000_04D2, 32'hFFFF_FFFF);
    issue("div_min", OP_DIV,  32'h8000_0000, 32'd1, 34, 32'h0000_0000, 32'h8000_0000);
    issue("divu_wide", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 34, 32'h7FFF_FFFE, 32'h0000_0001);

    // Acceptance held off by an external stall: nothing latched meanwhile
    op_i = OP_DIVU; a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF; start_i = 1'b1; stall_ext_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("extwait_busy", {63'b0, busy_o}, 64'd0);
      chk("extwait_stall", {63'b0, stall_o}, 64'd1);
      @(posedge clk); #1;
    end
    stall_ext_i = 1'b0;
    issue("divu_same", OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h0000_0001);

    // Flush at divide step 10
    op_i = OP_DIV; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_stall_same_cycle", {63'b0, stall_o}, 64'd0);
    chk("flush_busy_before_edge", {63'b0, busy_o}, 64'd1);
    @(posedge clk); #1;
    flush_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    chk("flush_busy_next", {63'b0, busy_o}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_hi_kept", {32'b0, hi_o}, {32'b0, m_hi});
    chk("flush_lo_kept", {32'b0, lo_o}, {32'b0, m_lo});

    // External stall holds COMMIT for three cycles, then a single write
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF2});
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFF2;
    op_i = OP_MULT; a_i = 32'd7; b_i = 32'hFFFF_FFFE; start_i = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    stall_ext_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("commit_hold_busy", {63'b0, busy_o}, 64'd1);
      chk("commit_hold_stall", {63'b0, stall_o}, 64'd0);
      chk("commit_hold_we", {63'b0, hilo_we_o}, 64'd0);
      @(posedge clk); #1;
    end
    stall_ext_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    chk("commit_release_busy", {63'b0, busy_o}, 64'd0);
    @(posedge clk); #1;

    // Flush beats an MTHI write
    op_i = OP_MTHI; a_i = 32'hDEAD_BEEF; start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("flush_mthi_hi", {32'b0, hi_o}, {32'b0, m_hi});

    // Unrecognised op is ignored
    @(posedge clk); #1;
    op_i = 8'h20; a_i = 32'h1; b_i = 32'h1; start_i = 1'b1;
    @(negedge clk);
    chk("other_op_stall", {63'b0, stall_o}, 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    chk("other_op_busy", {63'b0, busy_o}, 64'd0);
    @(posedge clk); #1;

    // Async reset in the middle of a multiply
    op_i = OP_MULTU; a_i = 32'h10; b_i = 32'h10; start_i = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", {63'b0, busy_o}, 64'd0);
    chk("async_rst_hi", {32'b0, hi_o}, 64'd0);
    chk("async_rst_lo", {32'b0, lo_o}, 64'd0);
    start_i = 1'b0;
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_hi", {32'b0, hi_o}, {32'b0, m_hi});
    chk("post_rst_lo", {32'b0, lo_o}, {32'b0, m_lo});
    chk("pending_expectations", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
